tdc_uart_reporter: RTL and testbench
====================================

// Module: tdc_uart_reporter
// PURPOSE
//   Downstream stage of the TDC. Watches the 32-bit measurement bus (t/clock_cycles) and,
//   whenever it changes, sends it to the host over a UART TX line (8N1).
//   Each report is a 5-byte frame: sync byte, then the measurement MSB byte first.
//   Sits between tdc and the board's FTDI TX pin.
// PARAMETERS
//   CLKS_PER_BIT  868    clock cycles per UART bit (100 MHz / 115200); legal range >= 2
//   SYNC_BYTE     8'hA5  frame header byte
// PORTS
//   clk        in   1   system clock; all logic on posedge
//   reset      in   1   asynchronous, active-high reset
//   t_in       in   32  measurement from tdc, held stable between updates
//   tx         out  1   UART serial out, idles high
//   busy       out  1   high while a frame is being shifted out
//   overrun    out  1   one-cycle pulse: pending measurement overwritten before it was sent
// BEHAVIOUR
//   Reset (async assert, sync release) values: tx=1, busy=0, overrun=0, t_prev=0,
//     pending_valid=0, FSM=IDLE. Reset mid-frame aborts immediately; tx returns high on assert.
//   Change detect: at each edge, compare t_in != t_prev, then t_prev <= t_in. A 0 after reset
//     is never reported. A return to an earlier value counts as a change.
//   On a change:
//     - IDLE: load frame {SYNC_BYTE, t_in[31:24], t_in[23:16], t_in[15:8], t_in[7:0]}.
//       The start bit appears on tx in the cycle after the detecting edge. busy rises the same cycle.
//     - Not IDLE: write t_in to the pending register.
//       If pending_valid was already 1, the old value is overwritten and overrun pulses for 1 cycle.
//       pending_valid <= 1.
//   Bit format: start(0), d0..d7 (LSB first), stop(1). Each bit is exactly CLKS_PER_BIT cycles.
//   Frame length: 5 x 10 x CLKS_PER_BIT cycles. Bytes go back-to-back with no idle gap.
//   FSM states:
//     - IDLE -> START (frame loaded)
//     - START -> DATA after CLKS_PER_BIT
//     - DATA -> STOP after 8 bits
//     - STOP -> START when byte_idx < 4 (byte_idx++)
//     - STOP -> IDLE or reload when byte_idx == 4
//   End of last stop bit:
//     - If pending_valid: load pending into the frame, clear pending_valid, next cycle is START.
//       busy stays high.
//     - Otherwise go to IDLE with busy=0.
//   Simultaneous: a change on the same edge the last stop bit ends is treated as arriving
//     while busy. It goes to pending and is sent immediately; it is never lost.
//   Widths:
//     - bit timer: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, wraps to 0.
//     - bit index: 3 bits. byte_idx: 3 bits.
//     - No arithmetic on t_in; it is forwarded bit-exact.
// STRUCTURE
//   tdc_pkg: SYNC_BYTE default, FRAME_BYTES=5, typedef enum logic [1:0] {IDLE,START,DATA,STOP}
//   tx_state_t. Shared with tdc and the host-side testbench decoder.
//   Sub-module uart_tx_byte (valid/ready byte serializer, CLKS_PER_BIT param).
//   The top holds change detection, the pending buffer and the frame/byte sequencer.
// TESTING  (CLKS_PER_BIT=4 unless noted)
//   1. Reset, t_in=0 for 500 cycles -> tx=1, busy=0, overrun=0 throughout.
//   2. t_in=32'h0000_1234 -> tx decodes to A5 00 00 12 34; start bit on cycle after change;
//      busy high exactly 200 cycles.
//   3. t_in 32'h11 then 32'h22 then 32'h33 during frame 1 -> frame 1=..11, overrun pulses once
//      (at 33), frame 2=..33 starts cycle after frame 1 stop; busy continuous 400 cycles.
//   4. Assert reset during byte 2 data bits -> tx=1 and busy=0 the same cycle (async); after release
//      with t_in unchanged from t_prev reset value 0, no frame.
//   5. Change coincident with last stop-bit edge -> value sent in immediately following frame,
//      no overrun.
//   6. CLKS_PER_BIT=868, t_in=32'hDEAD_BEEF -> UART monitor at 115200 @100 MHz
//      reads A5 DE AD BE EF.

Source files
------------

// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
//   Shared definitions for the TDC measurement path and its UART reporter:
//   default frame header byte, frame length, the UART serializer state type,
//   and a helper that picks one byte of a report frame.
//   The same package is used by tdc and by the host-side decoder.
// -----------------------------------------------------------------------------
package tdc_pkg;

  // Header byte that opens every report frame.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // One header byte followed by the four measurement bytes.
  localparam int FRAME_BYTES = 5;

  // Serializer bit-phase states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Byte idx of a frame: 0 is the header, 1..4 are the measurement MSB first.
  function automatic logic [7:0] frame_byte(input logic [7:0]  sync,
                                            input logic [31:0] meas,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = meas[31:24];
      3'd2:    b = meas[23:16];
      3'd3:    b = meas[15:8];
      3'd4:    b = meas[7:0];
      default: b = sync;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tdc_uart_reporter_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//   8N1 byte serializer with a valid/ready input. A byte accepted on a clock
//   edge drives its start bit from that same edge, so the line goes low in the
//   cycle right after the handshake. ready is also high during the final cycle
//   of the stop bit, which lets the next byte follow with no idle gap.
//
// Ports
//   clk    in   1  system clock, posedge
//   reset  in   1  asynchronous active-high reset; line returns high at once
//   valid  in   1  data holds a byte to send
//   data   in   8  byte to send, sampled when valid && ready
//   ready  out  1  serializer can accept a byte on this edge
//   done   out  1  final cycle of a stop bit
//   tx     out  1  registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_byte
  import tdc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  localparam int            TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_t     state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    shreg_r, shreg_s;
  logic          tx_r, tx_s;
  logic          bit_end_s;

  assign bit_end_s = (timer_r == T_LAST);
  assign done      = (state_r == STOP) && bit_end_s;
  assign ready     = (state_r == IDLE) || done;
  assign tx        = tx_r;

  // Next-state logic: handshake first, otherwise advance the current bit.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    bit_idx_s = bit_idx_r;
    shreg_s   = shreg_r;
    tx_s      = tx_r;
    if (valid && ready) begin
      state_s   = START;
      timer_s   = '0;
      bit_idx_s = 3'd0;
      shreg_s   = data;
      tx_s      = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timer_s = '0;
          tx_s    = 1'b1;
        end
        START: begin
          if (bit_end_s) begin
            state_s = DATA;
            timer_s = '0;
            tx_s    = shreg_r[0];
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            timer_s = '0;
            if (bit_idx_r == 3'd7) begin
              state_s = STOP;
              tx_s    = 1'b1;
            end else begin
              // shreg[0] is always the bit on the line; shift to expose the next.
              bit_idx_s = bit_idx_r + 3'd1;
              shreg_s   = {1'b0, shreg_r[7:1]};
              tx_s      = shreg_r[1];
            end
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            state_s = IDLE;
            timer_s = '0;
            tx_s    = 1'b1;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
        default: begin
          state_s = IDLE;
          timer_s = '0;
          tx_s    = 1'b1;
        end
      endcase
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      bit_idx_r <= 3'd0;
      shreg_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      bit_idx_r <= bit_idx_s;
      shreg_r   <= shreg_s;
      tx_r      <= tx_s;
    end
  end

endmodule

// File: rtl/tdc_uart_reporter.sv
// -----------------------------------------------------------------------------
// tdc_uart_reporter
//   Watches the 32-bit TDC measurement and, whenever it changes, sends a
//   5-byte report over UART: header byte, then the measurement MSB first.
//   A change that arrives while a frame is on the line is parked in a single
//   pending register; a second parked change replaces the first and raises
//   a one-cycle overrun pulse. The pending value goes out straight after the
//   current frame.
//
// Ports
//   clk      in   1   system clock, posedge
//   reset    in   1   asynchronous active-high reset, aborts any frame
//   t_in     in   32  measurement from tdc, stable between updates
//   tx       out  1   UART serial out, idles high
//   busy     out  1   high while a frame is being shifted out
//   overrun  out  1   one-cycle pulse when a pending value is overwritten
// -----------------------------------------------------------------------------
module tdc_uart_reporter
  import tdc_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] t_in,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  logic [31:0] t_prev_r, t_prev_s;
  logic [31:0] pending_r, pending_s;
  logic        pending_valid_r, pending_valid_s;
  logic [31:0] meas_r, meas_s;
  logic [2:0]  byte_idx_r, byte_idx_s;
  logic        busy_r, busy_s;
  logic        overrun_r, overrun_s;

  logic        change_s;
  logic        ser_valid_s;
  logic [7:0]  ser_data_s;
  logic        ser_ready_s;
  logic        ser_done_s;
  logic        byte_end_s;

  assign change_s   = (t_in != t_prev_r);
  assign byte_end_s = busy_r && ser_done_s;

  assign busy    = busy_r;
  assign overrun = overrun_r;

  // Byte serializer; tx comes straight from its output register.
  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .valid (ser_valid_s),
    .data  (ser_data_s),
    .ready (ser_ready_s),
    .done  (ser_done_s),
    .tx    (tx)
  );

  // Change detection, pending buffer and frame/byte sequencing.
  always_comb begin
    t_prev_s        = t_in;
    pending_s       = pending_r;
    pending_valid_s = pending_valid_r;
    meas_s          = meas_r;
    byte_idx_s      = byte_idx_r;
    busy_s          = busy_r;
    overrun_s       = 1'b0;
    ser_valid_s     = 1'b0;
    ser_data_s      = SYNC_BYTE;

    if (!busy_r) begin
      if (change_s && ser_ready_s) begin
        ser_valid_s = 1'b1;
        ser_data_s  = SYNC_BYTE;
        meas_s      = t_in;
        byte_idx_s  = 3'd0;
        busy_s      = 1'b1;
      end else begin
        busy_s = 1'b0;
      end
    end else if (byte_end_s && (byte_idx_r == LAST_IDX)) begin
      // Last stop bit ends here. A change on this very edge counts as
      // arriving while busy, so the parked value (if any) goes first and
      // the new one is parked behind it; otherwise the new one goes now.
      if (pending_valid_r) begin
        ser_valid_s = 1'b1;
        ser_data_s  = SYNC_BYTE;
        meas_s      = pending_r;
        byte_idx_s  = 3'd0;
        if (change_s) begin
          pending_s       = t_in;
          pending_valid_s = 1'b1;
        end else begin
          pending_valid_s = 1'b0;
        end
      end else if (change_s) begin
        ser_valid_s = 1'b1;
        ser_data_s  = SYNC_BYTE;
        meas_s      = t_in;
        byte_idx_s  = 3'd0;
      end else begin
        byte_idx_s = 3'd0;
        busy_s     = 1'b0;
      end
    end else begin
      if (byte_end_s) begin
        ser_valid_s = 1'b1;
        ser_data_s  = frame_byte(SYNC_BYTE, meas_r, byte_idx_r + 3'd1);
        byte_idx_s  = byte_idx_r + 3'd1;
      end else begin
        byte_idx_s = byte_idx_r;
      end
      if (change_s) begin
        pending_s       = t_in;
        pending_valid_s = 1'b1;
        overrun_s       = pending_valid_r;
      end else begin
        pending_valid_s = pending_valid_r;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_prev_r        <= 32'h0000_0000;
      pending_r       <= 32'h0000_0000;
      pending_valid_r <= 1'b0;
      meas_r          <= 32'h0000_0000;
      byte_idx_r      <= 3'd0;
      busy_r          <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      t_prev_r        <= t_prev_s;
      pending_r       <= pending_s;
      pending_valid_r <= pending_valid_s;
      meas_r          <= meas_s;
      byte_idx_r      <= byte_idx_s;
      busy_r          <= busy_s;
      overrun_r       <= overrun_s;
    end
  end

endmodule

// File: tb/tb_tdc_uart_reporter.sv
// -----------------------------------------------------------------------------
// tb_tdc_uart_reporter
//   Directed bench: a fast instance (4 clocks/bit) for framing, timing,
//   pending/overrun and reset behaviour, and a full-rate instance
//   (868 clocks/bit) decoded by the same UART receiver task.
// -----------------------------------------------------------------------------
module tb_tdc_uart_reporter;

  localparam int CPB     = 4;
  localparam int CPB_BIG = 868;

  logic        clk;
  logic        reset;
  logic [31:0] t_in;
  logic [31:0] t_in_big;
  logic        tx, busy, overrun;
  logic        tx_big, busy_big, overrun_big;
  logic        mon_big;
  logic        tx_mon;

  int err_cnt;
  int chk_cnt;

  // Free-running event counters, sampled on posedge (value of the previous cycle).
  int   busy_cyc, busy_rise, ovr_cyc, txlow_cyc;
  logic busy_d;

  int s_busy, s_rise, s_ovr, s_txlow;

  logic [7:0] rx [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_mon = mon_big ? tx_big : tx;

  tdc_uart_reporter #(
    .CLKS_PER_BIT (CPB),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .t_in    (t_in),
    .tx      (tx),
    .busy    (busy),
    .overrun (overrun)
  );

  tdc_uart_reporter #(
    .CLKS_PER_BIT (CPB_BIG)
  ) dut_big (
    .clk     (clk),
    .reset   (reset),
    .t_in    (t_in_big),
    .tx      (tx_big),
    .busy    (busy_big),
    .overrun (overrun_big)
  );

  always @(posedge clk) begin
    busy_d <= busy;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (busy === 1'b1 && busy_d !== 1'b1) busy_rise <= busy_rise + 1;
    if (overrun === 1'b1) ovr_cyc <= ovr_cyc + 1;
    if (tx === 1'b0) txlow_cyc <= txlow_cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_busy  = busy_cyc;
    s_rise  = busy_rise;
    s_ovr   = ovr_cyc;
    s_txlow = txlow_cyc;
  endtask

  // UART receiver: waits (bounded) for a start bit, samples mid-bit, checks stop.
  // Returns in the middle of the stop bit.
  task automatic recv_byte(input int cpb, output logic [7:0] b);
    int waited;
    waited = 0;
    b = 8'h00;
    while (tx_mon !== 1'b0 && waited < cpb * 30) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rx_start_seen", 32'(tx_mon), 32'd0);
    repeat (cpb / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      b[i] = tx_mon;
    end
    repeat (cpb) @(negedge clk);
    check_eq("rx_stop_bit", 32'(tx_mon), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    err_cnt  = 0;
    chk_cnt  = 0;
    reset    = 1'b1;
    t_in     = 32'h0;
    t_in_big = 32'h0;
    mon_big  = 1'b0;

    // 1. Reset state, then quiet input for 500 cycles.
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_tx_big", 32'(tx_big), 32'd1);
    check_eq("rst_busy_big", 32'(busy_big), 32'd0);
    reset = 1'b0;
    snap();
    repeat (500) @(negedge clk);
    check_eq("quiet_txlow", 32'(txlow_cyc - s_txlow), 32'd0);
    check_eq("quiet_busy", 32'(busy_cyc - s_busy), 32'd0);
    check_eq("quiet_overrun", 32'(ovr_cyc - s_ovr), 32'd0);

    // 2. Single frame: A5 00 00 12 34, start bit next cycle, busy 200 cycles.
    snap();
    t_in = 32'h0000_1234;
    check_eq("f1_tx_before", 32'(tx), 32'd1);
    @(negedge clk);
    check_eq("f1_start_next_cycle", 32'(tx), 32'd0);
    check_eq("f1_busy_next_cycle", 32'(busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      recv_byte(CPB, b);
      rx[k] = b;
    end
    check_eq("f1_b0", 32'(rx[0]), 32'hA5);
    check_eq("f1_b1", 32'(rx[1]), 32'h00);
    check_eq("f1_b2", 32'(rx[2]), 32'h00);
    check_eq("f1_b3", 32'(rx[3]), 32'h12);
    check_eq("f1_b4", 32'(rx[4]), 32'h34);
    repeat (10) @(negedge clk);
    check_eq("f1_busy_cycles", 32'(busy_cyc - s_busy), 32'd200);
    check_eq("f1_overrun", 32'(ovr_cyc - s_ovr), 32'd0);

    // 3. 11, then 22 and 33 during frame 1: 33 overwrites 22 with one overrun.
    snap();
    t_in = 32'h0000_0011;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          recv_byte(CPB, b);
          rx[k] = b;
        end
      end
      begin
        repeat (20) @(negedge clk);
        t_in = 32'h0000_0022;
        repeat (40) @(negedge clk);
        t_in = 32'h0000_0033;
      end
    join
    repeat (10) @(negedge clk);
    check_eq("ovr_f1", {rx[0], rx[1], rx[2], rx[3]}, 32'hA500_0000);
    check_eq("ovr_f1_lsb", 32'(rx[4]), 32'h11);
    check_eq("ovr_f2", {rx[5], rx[6], rx[7], rx[8]}, 32'hA500_0000);
    check_eq("ovr_f2_lsb", 32'(rx[9]), 32'h33);
    check_eq("ovr_pulses", 32'(ovr_cyc - s_ovr), 32'd1);
    check_eq("ovr_busy_cycles", 32'(busy_cyc - s_busy), 32'd400);
    check_eq("ovr_busy_rises", 32'(busy_rise - s_rise), 32'd1);

    // 4. Reset during byte 2 data bits: async abort, no frame after release.
    t_in = 32'hCAFE_F00D;
    repeat (96) @(negedge clk);
    check_eq("rst_mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    t_in  = 32'h0;
    #1;
    check_eq("rst_mid_tx", 32'(tx), 32'd1);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    snap();
    repeat (300) @(negedge clk);
    check_eq("rst_mid_txlow_after", 32'(txlow_cyc - s_txlow), 32'd0);
    check_eq("rst_mid_busy_after", 32'(busy_cyc - s_busy), 32'd0);

    // 5. Change on the edge that ends the last stop bit: sent next, no overrun.
    snap();
    t_in = 32'h0A0B_0C0D;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          recv_byte(CPB, b);
          rx[k] = b;
        end
      end
      begin
        repeat (200) @(negedge clk);
        t_in = 32'h0102_0304;
      end
    join
    repeat (10) @(negedge clk);
    check_eq("coin_f1", {rx[1], rx[2], rx[3], rx[4]}, 32'h0A0B_0C0D);
    check_eq("coin_f2_sync", 32'(rx[5]), 32'hA5);
    check_eq("coin_f2", {rx[6], rx[7], rx[8], rx[9]}, 32'h0102_0304);
    check_eq("coin_overrun", 32'(ovr_cyc - s_ovr), 32'd0);
    check_eq("coin_busy_cycles", 32'(busy_cyc - s_busy), 32'd400);

    // 6. Full-rate instance: A5 DE AD BE EF at 868 clocks per bit.
    mon_big  = 1'b1;
    t_in_big = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      recv_byte(CPB_BIG, b);
      rx[k] = b;
    end
    check_eq("big_sync", 32'(rx[0]), 32'hA5);
    check_eq("big_meas", {rx[1], rx[2], rx[3], rx[4]}, 32'hDEAD_BEEF);
    repeat (CPB_BIG) @(negedge clk);
    check_eq("big_busy_end", 32'(busy_big), 32'd0);
    check_eq("big_overrun", 32'(overrun_big), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
